// File: rtl/mole_pkg.sv
// Shared types and constants for the mole spawner.
// Holds the FSM state enum, board geometry, LFSR constants and level helpers.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        UP
    } state_e;

    localparam int          NUM_HOLES    = 16;
    localparam int          HOLE_W       = $clog2(NUM_HOLES);
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [1:0]  MAX_LEVEL    = 2'd3;

    // Speed level is hits/8, capped at MAX_LEVEL.
    function automatic logic [1:0] level_of(input logic [7:0] cnt);
        if (cnt[7:3] >= 5'(MAX_LEVEL)) begin
            return MAX_LEVEL;
        end
        return cnt[4:3];
    endfunction

    function automatic logic [NUM_HOLES-1:0] onehot_hole(
        input logic [HOLE_W-1:0] idx
    );
        return NUM_HOLES'(1) << idx;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR, right shifting, used as the hole source.
// Ports: clk_i, reset_i (async active-low), lfsr_o (current state).
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [15:0] lfsr_o
);

    // An all-zero seed would lock the register up.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: picks a hole, raises a one-hot mole after a gap, retires it as
// hit or miss. Ports: clk_i, reset_i (async low), enable_i, clear_i,
// whacked_i in; mole_o, hit_o, miss_o, hit/miss counts, level_o out.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int unsigned LIFE_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 whacked_i,
    output logic [NUM_HOLES-1:0] mole_o,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic [7:0]           hit_count_o,
    output logic [7:0]           miss_count_o,
    output logic [1:0]           level_o
);

    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES) - 32'd1;
    localparam logic [31:0] LIFE_32  = 32'(LIFE_CYCLES);

    state_e               state_q, state_d;
    logic [31:0]          timer_q, timer_d;
    logic [NUM_HOLES-1:0] mole_q, mole_d;
    logic [HOLE_W-1:0]    last_q, last_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [7:0]           hit_count_q, hit_count_d;
    logic [7:0]           miss_count_q, miss_count_d;
    logic [1:0]           level_q, level_d;

    logic [15:0]          lfsr;
    logic [HOLE_W-1:0]    pos;
    logic [HOLE_W-1:0]    cand;
    logic [31:0]          life_m1;
    logic                 hit_inc;
    logic                 miss_inc;
    logic                 unused_lfsr;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .lfsr_o  (lfsr)
    );

    assign pos         = lfsr[HOLE_W-1:0];
    assign unused_lfsr = ^lfsr[15:HOLE_W];

    // Never reuse the previous hole back to back.
    assign cand    = (pos == last_q) ? pos + HOLE_W'(1) : pos;
    assign life_m1 = (LIFE_32 >> level_q) - 32'd1;

    // State register and all other flops.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            mole_q       <= '0;
            last_q       <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            mole_q       <= mole_d;
            last_q       <= last_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            level_q      <= level_d;
        end
    end

    // Next state. Disable overrides everything else.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = GAP;
                GAP: begin
                    if (timer_q == 32'd0) begin
                        state_d = UP;
                    end
                end
                UP: begin
                    if (whacked_i || timer_q == 32'd0) begin
                        state_d = GAP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs, timer and hole bookkeeping.
    always_comb begin
        timer_d  = timer_q;
        mole_d   = mole_q;
        last_d   = last_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        if (!enable_i) begin
            mole_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    mole_d  = '0;
                    timer_d = GAP_LOAD;
                end
                GAP: begin
                    if (timer_q == 32'd0) begin
                        mole_d  = onehot_hole(cand);
                        last_d  = cand;
                        // Lifetime is fixed at entry for this mole.
                        timer_d = life_m1;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                UP: begin
                    if (whacked_i) begin
                        mole_d  = '0;
                        hit_d   = 1'b1;
                        hit_inc = 1'b1;
                        timer_d = GAP_LOAD;
                    end else if (timer_q == 32'd0) begin
                        mole_d   = '0;
                        miss_d   = 1'b1;
                        miss_inc = 1'b1;
                        timer_d  = GAP_LOAD;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                default: begin
                    mole_d  = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Saturating counters; clear beats a coincident increment.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (clear_i) begin
            hit_count_d  = '0;
            miss_count_d = '0;
        end else begin
            if (hit_inc && hit_count_q != 8'hFF) begin
                hit_count_d = hit_count_q + 8'd1;
            end
            if (miss_inc && miss_count_q != 8'hFF) begin
                miss_count_d = miss_count_q + 8'd1;
            end
        end
        level_d = level_of(hit_count_d);
    end

    assign mole_o       = mole_q;
    assign hit_o        = hit_q;
    assign miss_o       = miss_q;
    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
    assign level_o      = level_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Testbench for mole_spawner with LIFE_CYCLES=8, GAP_CYCLES=4.
// Table-driven miss/hit paths plus directed multi-cycle corner sequences.
module tb_mole_spawner;

    localparam int LIFE = 8;
    localparam int GAPC = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        clear_i;
    logic        whacked_i;
    logic [15:0] mole_o;
    logic        hit_o;
    logic        miss_o;
    logic [7:0]  hit_count_o;
    logic [7:0]  miss_count_o;
    logic [1:0]  level_o;

    always #5 clk = ~clk;

    mole_spawner #(
        .LIFE_CYCLES (LIFE),
        .GAP_CYCLES  (GAPC),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .whacked_i    (whacked_i),
        .mole_o       (mole_o),
        .hit_o        (hit_o),
        .miss_o       (miss_o),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o),
        .level_o      (level_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference LFSR and candidate-hole model.
    logic [15:0] m_lfsr;
    logic [3:0]  m_cand;
    logic [3:0]  m_last;
    logic [15:0] prev_mole;
    logic [15:0] last_nz;

    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            m_lfsr <= 16'hACE1;
            m_cand <= 4'd0;
        end else begin
            if (m_lfsr[3:0] == m_last) begin
                m_cand <= m_lfsr[3:0] + 4'd1;
            end else begin
                m_cand <= m_lfsr[3:0];
            end
            if (m_lfsr[0]) begin
                m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
            end else begin
                m_lfsr <= m_lfsr >> 1;
            end
        end
    end

    typedef struct {
        logic       en;
        logic       wh;
        logic       up;
        logic       hit;
        logic       miss;
        logic [7:0] hc;
        logic [7:0] mc;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(logic en, logic wh, logic up, logic hit,
                                logic miss, logic [7:0] hc, logic [7:0] mc);
        vec_t v;
        v.en = en; v.wh = wh; v.up = up; v.hit = hit;
        v.miss = miss; v.hc = hc; v.mc = mc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic wh, input logic clr);
        logic [15:0] exp_m;
        enable_i  = en;
        whacked_i = wh;
        clear_i   = clr;
        @(posedge clk);
        #1;
        if (mole_o != 16'h0 && prev_mole == 16'h0) begin
            exp_m = 16'h1 << m_cand;
            check("new_mole", 32'(mole_o), 32'(exp_m));
            check("hole_changed", 32'(mole_o != last_nz), 32'd1);
            m_last  = m_cand;
            last_nz = mole_o;
        end
        prev_mole = mole_o;
    endtask

    task automatic wait_mole();
        int k = 0;
        while (mole_o == 16'h0 && k < 20) begin
            step(1'b1, 1'b0, 1'b0);
            k++;
        end
        check("mole_timeout", 32'(mole_o != 16'h0), 32'd1);
    endtask

    task automatic hit_one();
        wait_mole();
        step(1'b1, 1'b1, 1'b0);
        check("hit_pulse", {hit_o, miss_o, mole_o}, {2'b10, 16'h0});
    endtask

    task automatic measure_up(output int n);
        wait_mole();
        n = 0;
        while (mole_o != 16'h0 && n < 20) begin
            n++;
            step(1'b1, 1'b0, 1'b0);
        end
        check("miss_after_up", 32'(miss_o), 32'd1);
    endtask

    initial begin
        int n_up;
        int nm;
        int cyc;
        logic [7:0] hc_s, mc_s;

        m_last    = 4'd0;
        prev_mole = 16'h0;
        last_nz   = 16'h0;
        enable_i  = 1'b0;
        clear_i   = 1'b0;
        whacked_i = 1'b0;
        reset_i   = 1'b0;

        // Miss path then hit path, one record per clock edge.
        for (int i = 0; i < 4; i++) vt[i] = mk(1, 0, 0, 0, 0, 0, 0);
        for (int i = 4; i < 12; i++) vt[i] = mk(1, 0, 1, 0, 0, 0, 0);
        vt[12] = mk(1, 0, 0, 0, 1, 0, 1);
        for (int i = 13; i < 16; i++) vt[i] = mk(1, 0, 0, 0, 0, 0, 1);
        for (int i = 16; i < 19; i++) vt[i] = mk(1, 0, 1, 0, 0, 0, 1);
        vt[19] = mk(1, 1, 0, 1, 0, 1, 1);
        for (int i = 20; i < 23; i++) vt[i] = mk(1, 0, 0, 0, 0, 1, 1);
        vt[23] = mk(1, 0, 1, 0, 0, 1, 1);

        #12;
        check("reset_state",
              {mole_o, hit_o, miss_o, hit_count_o, miss_count_o, level_o},
              32'h0);
        @(negedge clk);
        reset_i = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("idle_quiet", 32'(mole_o), 32'h0);

        for (int i = 0; i < 24; i++) begin
            step(vt[i].en, vt[i].wh, 1'b0);
            check($sformatf("vec%0d", i),
                  {mole_o != 16'h0, hit_o, miss_o, hit_count_o,
                   miss_count_o, level_o},
                  {vt[i].up, vt[i].hit, vt[i].miss, vt[i].hc,
                   vt[i].mc, 2'd0});
        end

        // Whack on the last UP cycle: hit wins over expiry.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        check("still_up_last", 32'(mole_o != 16'h0), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check("collision",
              {mole_o, hit_o, miss_o, hit_count_o, miss_count_o},
              {16'h0, 2'b10, 8'd2, 8'd1});

        // Level progression.
        for (int i = 0; i < 6; i++) hit_one();
        check("lvl1", {hit_count_o, 6'd0, level_o}, {8'd8, 8'd1});
        measure_up(n_up);
        check("up_len_lvl1", n_up, 4);
        for (int i = 0; i < 8; i++) hit_one();
        check("lvl2", {hit_count_o, 6'd0, level_o}, {8'd16, 8'd2});
        for (int i = 0; i < 8; i++) hit_one();
        check("lvl3", {hit_count_o, 6'd0, level_o}, {8'd24, 8'd3});
        measure_up(n_up);
        check("up_len_lvl3", n_up, 1);
        check("mc_before_clear", 32'(miss_count_o), 32'd3);
        step(1'b1, 1'b0, 1'b1);
        check("clear",
              {hit_count_o, miss_count_o, level_o}, 32'h0);

        // Disable during UP.
        wait_mole();
        hc_s = hit_count_o;
        mc_s = miss_count_o;
        step(1'b0, 1'b0, 1'b0);
        check("disable",
              {mole_o, hit_o, miss_o, hit_count_o, miss_count_o},
              {16'h0, 2'b00, hc_s, mc_s});
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("idle_hold", 32'(mole_o), 32'h0);

        // Whack held through IDLE and GAP is ignored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check("wh_in_gap",
              {mole_o != 16'h0, hit_o, hit_count_o},
              {1'b1, 1'b0, 8'd0});

        // Async reset mid-UP.
        measure_up(n_up);
        check("up_len_lvl0", n_up, 8);
        wait_mole();
        check("pre_reset_mc", 32'(miss_count_o), 32'd1);
        #2;
        reset_i = 1'b0;
        #1;
        check("async_reset",
              {mole_o, hit_o, miss_o, hit_count_o, miss_count_o, level_o},
              32'h0);
        m_last    = 4'd0;
        prev_mole = 16'h0;
        last_nz   = 16'h0;
        @(negedge clk);
        reset_i = 1'b1;

        // Miss counter saturation.
        nm  = 0;
        cyc = 0;
        while (nm < 300 && cyc < 6000) begin
            step(1'b1, 1'b0, 1'b0);
            if (miss_o) nm++;
            cyc++;
        end
        check("sat_budget", 32'(nm), 32'd300);
        check("sat_count",
              {hit_count_o, miss_count_o}, {8'd0, 8'd255});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mole_spawner.md
# mole_spawner

Game-side source of mole positions for the whack-a-mole datapath. A free-running LFSR picks one of 16 holes, and the block raises a one-hot mole after a gap period and holds it for a lifetime window. It then retires the mole as a hit (on `whacked_i` from the whack handler) or as a miss (on lifetime expiry). Its `mole_o` drives the whack handler's mole input and the LED display. Its hit/miss counters feed the score display.

## Interface
- `LIFE_CYCLES`, default 50_000_000: base mole lifetime in clocks, ≥ 8.
- `GAP_CYCLES`, default 25_000_000: empty-board time between moles in clocks, ≥ 1.
- `LFSR_SEED`, default 16'hACE1: reset value of the LFSR; a seed of 0 is replaced by 16'hACE1.
- `clk_i` in 1: system clock; all state changes on its rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: game running; low forces IDLE.
- `clear_i` in 1: synchronous clear of counters and level.
- `whacked_i` in 1: hit indication from the whack handler; sampled only in UP.
- `mole_o` out 16: one-hot active mole, or 0 when no mole is up.
- `hit_o` out 1: one-cycle pulse per hit.
- `miss_o` out 1: one-cycle pulse per miss.
- `hit_count_o` out 8: saturating hit count.
- `miss_count_o` out 8: saturating miss count.
- `level_o` out 2: current speed level.

## Operation
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts right.
  - Advances every clock out of reset, independent of state.
- Candidate hole:
  - `pos = lfsr[3:0]`.
  - If `pos` equals the last used hole, use `(pos+1) mod 16` instead.
  - The last used hole resets to 0.
- States: IDLE, GAP, UP. Timer is 32-bit.
- IDLE:
  - `mole_o` = 0.
  - `enable_i`=1 → GAP, timer ← GAP_CYCLES−1.
- GAP:
  - timer≠0 → decrement.
  - timer=0 → UP: `mole_o` ← onehot(candidate), last hole ← candidate, timer ← `life_len`−1.
- UP, in priority order:
  - `whacked_i`=1 → GAP: `mole_o` ← 0, `hit_o` ← 1, hit count +1.
  - Else timer=0 → GAP: `mole_o` ← 0, `miss_o` ← 1, miss count +1.
  - Else decrement timer.
  - On entry to GAP, timer ← GAP_CYCLES−1.
- `enable_i`=0 in any state:
  - Next state IDLE, `mole_o` ← 0.
  - No hit/miss is recorded; counters hold.
  - `enable_i` takes priority over `whacked_i` and timer expiry.
- Level and lifetime:
  - `level = min(hit_count[7:3], 3)`.
  - `life_len = LIFE_CYCLES >> level`.
  - `life_len` is latched on UP entry; a level change mid-mole does not alter the current mole.
- Counters saturate at 255.
- `clear_i`:
  - Zeroes both counters the following edge; level follows to 0.
  - State, LFSR and `mole_o` are unaffected.
  - If clear and a hit/miss increment coincide, clear wins.
- `whacked_i` in IDLE or GAP is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `mole_o`=0, `hit_o`=0, `miss_o`=0, `hit_count_o`=0, `miss_count_o`=0, `level_o`=0.
  - State IDLE, LFSR=seed, last hole 0.
- Reset asserted mid-operation clears all outputs immediately (asynchronously).
- GAP lasts exactly GAP_CYCLES clocks. `mole_o` goes non-zero at the edge ending the last GAP cycle.
- UP lasts at most `life_len` clocks.
- On a whack sampled at edge E:
  - `mole_o`=0 and `hit_o`=1 from E.
  - `hit_o` drops at E+1.
  - The next mole appears at E+GAP_CYCLES.
- `miss_o` has the same shape as `hit_o`.
- `mole_o` never has more than one bit set.

## Structure
- Package `mole_pkg` holds:
  - state enum {IDLE, GAP, UP};
  - `NUM_HOLES`=16;
  - `LFSR_MASK`=16'hB400;
  - `DEFAULT_SEED`=16'hACE1;
  - `MAX_LEVEL`=3.
- Sub-module `mole_lfsr`:
  - Contents: 16-bit Galois LFSR.
  - Ports: clock, reset, seed parameter, 16-bit state output.
- FSM, timer, hole select and counters live in `mole_spawner`.

## Test plan
Bench parameters: LIFE_CYCLES=8, GAP_CYCLES=4.

- Miss path: `enable_i` 0→1 →
  - `mole_o` one-hot after 4 clocks and held 8 clocks;
  - then `miss_o` 1-cycle pulse, `miss_count_o`=1, `mole_o`=0 for 4 clocks.
- Hit path: `whacked_i` pulse on the 3rd UP cycle →
  - `mole_o`=0 and `hit_o` high next cycle;
  - `hit_count_o`=1, no `miss_o`;
  - next mole 4 clocks later in a different hole.
- Hit/expiry collision: `whacked_i`=1 on the final UP cycle (timer=0) → `hit_o` only, `hit_count_o`+1, `miss_count_o` unchanged.
- Level progression:
  - 8 hits → `level_o`=1, UP lasts 4 clocks;
  - 24 hits → `level_o`=3, UP lasts 1 clock;
  - `clear_i` → counters and level return to 0.
- Disable and ignore:
  - `enable_i`=0 during UP → `mole_o`=0 next edge, IDLE, counters held;
  - `whacked_i` held high through GAP → no hit recorded.
- Async reset and saturation:
  - `reset_i`=0 mid-UP → `mole_o`, counters, `level_o` are 0 before the next clock edge;
  - 300 misses → `miss_count_o` stays 255.
